// File: rtl/match_report_fifo.sv
// Match report buffer: captures unique matcher reports into a FIFO and presents them on valid/ready.
// Optional macro MATCH_REPORT_LENGTH_EN adds out_len and rejects reports with end < start.
module match_report_fifo #(
    parameter int DEPTH = 8,
    parameter int POS_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_match,
    input  logic             in_rdy,
    input  logic [POS_W-1:0] in_start,
    input  logic [POS_W-1:0] in_end,
    input  logic             stream_end,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [POS_W-1:0] out_start,
    output logic [POS_W-1:0] out_end,
    output logic [CNT_W-1:0] match_count,
    output logic             overflow,
    output logic             done
`ifdef MATCH_REPORT_LENGTH_EN
    ,
    output logic [POS_W-1:0] out_len
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_settle;
    logic [1:0]       w_settle_next;

    logic [POS_W-1:0] r_mem_start [DEPTH];
    logic [POS_W-1:0] r_mem_end   [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    logic             r_prev_hit;
    logic             r_last_vld;
    logic [POS_W-1:0] r_last_start;
    logic [POS_W-1:0] r_last_end;

    logic             r_out_valid;
    logic [POS_W-1:0] r_out_start;
    logic [POS_W-1:0] r_out_end;
    logic [POS_W-1:0] r_out_len;
    logic [CNT_W-1:0] r_match_count;
    logic             r_overflow;
    logic             r_done;

    logic             w_event;
    logic             w_dup;
    logic             w_len_bad;
    logic             w_accept;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [AW:0]      w_wr_next;
    logic [AW:0]      w_rd_next;
    logic             w_empty_next;
    logic             w_head_fwd;
    logic [POS_W-1:0] w_head_start;
    logic [POS_W-1:0] w_head_end;

    assign w_event = in_rdy & in_match & ~r_prev_hit;
    assign w_dup   = r_last_vld && (in_start == r_last_start) && (in_end == r_last_end);
`ifdef MATCH_REPORT_LENGTH_EN
    assign w_len_bad = (in_end < in_start);
`else
    assign w_len_bad = 1'b0;
`endif
    assign w_accept = w_event & ~w_dup & ~w_len_bad;

    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    // A pop in the same cycle frees the slot a push into a full FIFO needs
    assign w_pop   = r_out_valid & out_ready & ~w_empty;
    assign w_push  = w_accept & (~w_full | w_pop);
    assign w_drop  = w_accept & w_full & ~w_pop;

    assign w_wr_next    = r_wr_ptr + {{AW{1'b0}}, w_push};
    assign w_rd_next    = r_rd_ptr + {{AW{1'b0}}, w_pop};
    assign w_empty_next = (w_wr_next == w_rd_next);

    // The entry being written this edge becomes the head when it lands at the next read slot
    assign w_head_fwd   = w_push && (w_rd_next == r_wr_ptr);
    assign w_head_start = w_head_fwd ? in_start : r_mem_start[w_rd_next[AW-1:0]];
    assign w_head_end   = w_head_fwd ? in_end   : r_mem_end[w_rd_next[AW-1:0]];

    // Next-state and settle-counter logic
    always_comb begin
        w_state_next  = r_state;
        w_settle_next = r_settle;
        case (r_state)
            S_IDLE: begin
                if (stream_end) begin
                    w_state_next  = S_FLUSH;
                    w_settle_next = 2'd2;
                end else if (in_rdy) begin
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (stream_end) begin
                    w_state_next  = S_FLUSH;
                    w_settle_next = 2'd2;
                end else begin
                    w_state_next = S_RUN;
                end
            end
            S_FLUSH: begin
                if (r_settle != 2'd0) begin
                    w_settle_next = r_settle - 2'd1;
                end else if (w_empty) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_FLUSH;
                end
            end
            S_DONE:  w_state_next = S_DONE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_start[r_wr_ptr[AW-1:0]] <= in_start;
            r_mem_end[r_wr_ptr[AW-1:0]]   <= in_end;
        end
    end

    // Control, capture tracking, counters and registered head outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_settle      <= 2'd0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_prev_hit    <= 1'b0;
            r_last_vld    <= 1'b0;
            r_last_start  <= '0;
            r_last_end    <= '0;
            r_out_valid   <= 1'b0;
            r_out_start   <= '0;
            r_out_end     <= '0;
            r_out_len     <= '0;
            r_match_count <= '0;
            r_overflow    <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_settle   <= w_settle_next;
            r_wr_ptr   <= w_wr_next;
            r_rd_ptr   <= w_rd_next;
            r_prev_hit <= in_match & in_rdy;
            if (w_accept) begin
                r_last_vld   <= 1'b1;
                r_last_start <= in_start;
                r_last_end   <= in_end;
                if (r_match_count != {CNT_W{1'b1}}) begin
                    r_match_count <= r_match_count + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            r_out_valid <= ~w_empty_next;
            if (!w_empty_next) begin
                r_out_start <= w_head_start;
                r_out_end   <= w_head_end;
                r_out_len   <= w_head_end - w_head_start + {{(POS_W-1){1'b0}}, 1'b1};
            end
            r_done <= (w_state_next == S_DONE) && w_empty_next;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_start   = r_out_start;
    assign out_end     = r_out_end;
    assign match_count = r_match_count;
    assign overflow    = r_overflow;
    assign done        = r_done;
`ifdef MATCH_REPORT_LENGTH_EN
    assign out_len     = r_out_len;
`else
    logic w_len_unused;
    assign w_len_unused = ^r_out_len;
`endif

endmodule

// File: tb/tb_match_report_fifo.sv
// Scoreboard bench for match_report_fifo: directed reports queue expected pops, a monitor checks them.
module tb_match_report_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_match = 1'b0;
    logic        in_rdy = 1'b0;
    logic [31:0] in_start = 32'd0;
    logic [31:0] in_end = 32'd0;
    logic        stream_end = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_start;
    logic [31:0] out_end;
    logic [15:0] match_count;
    logic        overflow;
    logic        done;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];

    match_report_fifo #(.DEPTH(8), .POS_W(32), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_match   (in_match),
        .in_rdy     (in_rdy),
        .in_start   (in_start),
        .in_end     (in_end),
        .stream_end (stream_end),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_start  (out_start),
        .out_end    (out_end),
        .match_count(match_count),
        .overflow   (overflow),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Monitor: every pop presented by the DUT is compared against the scoreboard head
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL pop_unexpected got %0d/%0d want nothing", out_start, out_end);
            end else begin
                logic [63:0] exp_v;
                exp_v = exp_q.pop_front();
                if ({out_start, out_end} !== exp_v) begin
                    n_errors++;
                    $display("FAIL pop_data got %0d/%0d want %0d/%0d",
                             out_start, out_end, exp_v[63:32], exp_v[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_match = 1'b0;
        out_ready = 1'b0;
        stream_end = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic report(input logic [31:0] s, input logic [31:0] e, input bit stored);
        in_start = s;
        in_end = e;
        in_match = 1'b1;
        if (stored) exp_q.push_back({s, e});
        tick();
        in_match = 1'b0;
        tick();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (out_valid && n < 40) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        check(name, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        do_reset();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_start", out_start, 32'd0);
        check("rst_out_end", out_end, 32'd0);
        check("rst_match_count", {16'd0, match_count}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);

        // Single report held high for five cycles
        in_rdy = 1'b1;
        in_start = 32'd3;
        in_end = 32'd9;
        in_match = 1'b1;
        exp_q.push_back({32'd3, 32'd9});
        check("single_valid_before", {31'd0, out_valid}, 32'd0);
        tick();
        check("single_valid_latency", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 4; i++) tick();
        in_match = 1'b0;
        tick();
        check("single_count", {16'd0, match_count}, 32'd1);
        drain("single_drain");

        // Dedup of repeated pair
        do_reset();
        report(32'd3, 32'd9, 1'b1);
        report(32'd3, 32'd9, 1'b0);
        report(32'd12, 32'd17, 1'b1);
        check("dedup_count", {16'd0, match_count}, 32'd2);
        drain("dedup_drain");

        // Overflow: nine reports into eight slots
        do_reset();
        for (int i = 0; i < 9; i++) report(i, i + 1, i < 8);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        check("ovf_count", {16'd0, match_count}, 32'd9);
        drain("ovf_drain");

        // Full FIFO with simultaneous pop and push
        do_reset();
        for (int i = 0; i < 8; i++) report(i, i + 1, 1'b1);
        check("full_no_ovf", {31'd0, overflow}, 32'd0);
        in_start = 32'd20;
        in_end = 32'd25;
        in_match = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back({32'd20, 32'd25});
        tick();
        in_match = 1'b0;
        out_ready = 1'b0;
        tick();
        check("pushpop_ovf", {31'd0, overflow}, 32'd0);
        check("pushpop_count", {16'd0, match_count}, 32'd9);
        report(32'd30, 32'd31, 1'b0);
        check("pushpop_still_full", {31'd0, overflow}, 32'd1);
        check("pushpop_count2", {16'd0, match_count}, 32'd10);
        drain("pushpop_drain");

        // Flush and done, with a late report one cycle after stream_end
        do_reset();
        report(32'd4, 32'd8, 1'b1);
        stream_end = 1'b1;
        tick();
        stream_end = 1'b0;
        check("flush_done_early", {31'd0, done}, 32'd0);
        in_start = 32'd5;
        in_end = 32'd10;
        in_match = 1'b1;
        exp_q.push_back({32'd5, 32'd10});
        tick();
        in_match = 1'b0;
        check("flush_done_pending", {31'd0, done}, 32'd0);
        check("flush_late_count", {16'd0, match_count}, 32'd2);
        out_ready = 1'b1;
        begin
            int n;
            n = 0;
            while (!done && n < 20) begin
                if (out_valid) check("flush_done_while_busy", {31'd0, done}, 32'd0);
                tick();
                n++;
            end
        end
        out_ready = 1'b0;
        check("flush_done", {31'd0, done}, 32'd1);
        check("flush_empty", {31'd0, out_valid}, 32'd0);
        report(32'd6, 32'd11, 1'b1);
        check("done_drops_on_capture", {31'd0, done}, 32'd0);
        drain("done_drain");
        tick();
        check("done_reasserts", {31'd0, done}, 32'd1);

        // Reset mid-run discards queued entries and the last-capture record
        do_reset();
        report(32'd1, 32'd2, 1'b0);
        report(32'd2, 32'd3, 1'b0);
        report(32'd3, 32'd4, 1'b0);
        do_reset();
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_count", {16'd0, match_count}, 32'd0);
        check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        report(32'd3, 32'd4, 1'b1);
        check("post_rst_count", {16'd0, match_count}, 32'd1);
        check("post_rst_valid", {31'd0, out_valid}, 32'd1);
        drain("post_rst_drain");

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
